blft_win_gen: RTL and testbench
===============================

Name: blft_win_gen

Overview:
- Upstream feeder for the bilateral filter core.
- Accepts a raster-order pixel stream (one 9-bit pixel per accepted cycle, with its 16-bit address).
- Emits, for every pixel of the frame, its 3x3 neighbourhood window plus the centre address.
- Out-of-frame neighbours are zero-padded. Two internal line buffers; no backpressure.

Parameters:
IMG_W, 256, frame width in pixels (>=2; IMG_W*IMG_H <= 65536)
IMG_H, 256, frame height in pixels (>=2)
PIX_W, 9, pixel width in bits
ADDR_W, 16, address width in bits

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  pixel present this cycle
in_addr  in  ADDR_W  raster address of in_data (r*IMG_W+c)
in_data  in  PIX_W  pixel value, unsigned
out_valid  out  1  window valid this cycle
out_addr  out  ADDR_W  raster address of window centre
out_win  out  9*PIX_W  window; element (i,j) at [PIX_W*(3*i+j) +: PIX_W], i=row 0 top, j=col 0 left, centre index 4
out_done  out  1  one-cycle pulse with the last window of a frame
addr_err  out  1  sticky: in_addr differed from expected raster index

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; there is no asynchronous reset.
- Reset values: out_valid=0, out_addr=0, out_win=0, out_done=0, addr_err=0. Counters are cleared and the FSM enters IDLE. Line-buffer contents are don't-care because stale data is always masked.
- Reset mid-frame: the partial frame is abandoned. The next accepted pixel is treated as address 0.
- Definitions: N = IMG_W*IMG_H; k = running accept count within the frame.
- FSM states:
  - IDLE: waits for in_valid; goes to FILL on the first accept.
  - FILL: counts accepts; no output while k < IMG_W+1.
  - RUN: each accept of pixel k emits the window centred at k-IMG_W-1.
  - FLUSH: entered the cycle after pixel N-1 is accepted. Pushes IMG_W+1 internal zero pixels, one per cycle, emitting centres N-IMG_W .. N-1. Returns to IDLE after the last one.
- Output timing: out_valid, out_addr and out_win are registered and appear the cycle after the accepting edge. Exactly N windows are emitted per frame, in raster order.
- in_valid gaps in FILL/RUN produce identical output gaps; pipeline contents are held.
- in_valid during FLUSH: the pixel is ignored and addr_err is set.
- Masking by centre (r,c):
  - r==0: top row zeroed.
  - r==IMG_H-1: bottom row zeroed.
  - c==0: left column zeroed.
  - c==IMG_W-1: right column zeroed.
  - This also suppresses line-wrap data.
- Address check: in_addr is compared with the expected k. A mismatch sets addr_err, which stays set until rst. Data is still consumed at position k; in_addr is otherwise unused.
- out_done: asserts together with out_valid for centre N-1.
- Back-to-back frames: a frame may start in the cycle after out_done.

Optional Feature:
- Macro: BLFT_EDGE_REPLICATE_EN.
- When defined: out-of-frame neighbours take the value of the nearest in-frame pixel, clamping row first, then column; corners take the corner pixel.
- When undefined: out-of-frame neighbours are zero-padded (the default described above).
- Latency, ports and window count are identical in both builds.

Decomposition:
- blft_pkg: PIX_W and ADDR_W constants, the window-index localparam for the centre (4), and the FSM state enum {IDLE, FILL, RUN, FLUSH}.
- Sub-module blft_line_buf: an IMG_W-deep, PIX_W-wide delay line with a shift enable, instantiated twice (row r-1 and row r-2 taps).
- Top level holds the 3x3 shift registers, counters, masking and FSM.

Test Plan (IMG_W=IMG_H=4, pixel value = address):
- Continuous frame 0..15 -> 16 windows, one cycle after accepts 5..15 then 5 flush cycles. Centre 0 = [0,0,0; 0,0,1; 0,4,5].
- Interior and right-edge windows: centre 5 = [0,1,2; 4,5,6; 8,9,10]; centre 7 = [2,3,0; 6,7,0; 10,11,0]. Last centre 15 = [10,11,0; 14,15,0; 0,0,0] with out_done=1.
- Random in_valid gaps (~50% duty) -> same 16 windows in the same order; out_valid count = 16; addr_err=0.
- rst asserted after pixel 8, then a full frame -> outputs all zero in the reset cycle; the next frame matches the first scenario exactly.
- in_addr 7 sent as 9 -> addr_err rises the cycle after and stays 1; window count is still 16.
- With BLFT_EDGE_REPLICATE_EN: centre 0 = [0,0,1; 0,0,1; 4,4,5]; centre 15 = [10,11,11; 14,15,15; 14,15,15].

Source files
------------

// File: rtl/blft_pkg.sv
// blft_pkg
//   Shared constants and types for the bilateral-filter window generator.
//   PIX_W      : pixel width in bits
//   ADDR_W     : raster address width in bits
//   WIN_CENTRE : flat index of the centre element inside a 3x3 window
//   state_t    : window generator FSM states
package blft_pkg;

  localparam int PIX_W      = 9;
  localparam int ADDR_W     = 16;
  localparam int WIN_CENTRE = 4;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

endpackage

// File: rtl/blft_line_buf.sv
// blft_line_buf
//   Fixed-length delay line: dout is the value that was shifted in DEPTH
//   shift-enabled cycles ago. Contents are not reset; the consumer masks
//   anything that predates the current frame.
// Ports:
//   clk      : clock, rising edge
//   shift_en : advance the delay line by one position
//   din      : value entering the line
//   dout     : oldest value in the line
module blft_line_buf
  import blft_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/blft_win_gen.sv
// blft_win_gen
//   Turns a raster pixel stream into one 3x3 neighbourhood window per pixel.
//   Out-of-frame neighbours are zero-padded by default. Defining the macro
//   BLFT_EDGE_REPLICATE_EN instead replicates the nearest in-frame pixel
//   (row clamp first, then column clamp).
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : pixel present this cycle
//   in_addr   : raster address of in_data, checked against the accept count
//   in_data   : pixel value
//   out_valid : window valid this cycle
//   out_addr  : raster address of the window centre
//   out_win   : window, element (i,j) at [PIX_W*(3*i+j) +: PIX_W]
//   out_done  : pulse with the last window of a frame
//   addr_err  : sticky address mismatch / pixel-during-flush flag
module blft_win_gen
  import blft_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [PIX_W-1:0]     in_data,
  output logic                 out_valid,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [9*PIX_W-1:0]   out_win,
  output logic                 out_done,
  output logic                 addr_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(IMG_W*IMG_H-1);
  localparam logic [ADDR_W-1:0] FIRST_EMIT = ADDR_W'(IMG_W+1);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(IMG_W-1);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(IMG_H-1);
  localparam int                MID        = WIN_CENTRE - 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   k_cnt;
  logic [ADDR_W-1:0]   ctr_addr, ctr_row, ctr_col;
  logic                accept, emit, shift_en;
  logic [PIX_W-1:0]    push_pix, tap1, tap2;
  logic [PIX_W-1:0]    win_q  [9];
  logic [PIX_W-1:0]    win_sh [9];
  logic [PIX_W-1:0]    win_m  [9];
  logic [9*PIX_W-1:0]  win_flat;
  logic                top_out, bot_out, left_out, right_out;

  // Row r-1 and row r-2 taps: the second buffer is fed by the first.
  blft_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk      (clk),
    .shift_en (shift_en),
    .din      (push_pix),
    .dout     (tap1)
  );

  blft_line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk      (clk),
    .shift_en (shift_en),
    .din      (tap1),
    .dout     (tap2)
  );

  // FLUSH pushes zero pixels so the last IMG_W+1 centres drain out.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    emit      = 1'b0;
    shift_en  = 1'b0;
    push_pix  = '0;
    case (state)
      IDLE: begin
        accept   = in_valid;
        shift_en = in_valid;
        push_pix = in_data;
        if (in_valid) state_nxt = FILL;
      end
      FILL: begin
        accept   = in_valid;
        shift_en = in_valid;
        push_pix = in_data;
        emit     = in_valid && (k_cnt >= FIRST_EMIT);
        if (in_valid) begin
          if (k_cnt == LAST_IDX)        state_nxt = FLUSH;
          else if (k_cnt >= FIRST_EMIT) state_nxt = RUN;
        end
      end
      RUN: begin
        accept   = in_valid;
        shift_en = in_valid;
        push_pix = in_data;
        emit     = in_valid;
        if (in_valid && (k_cnt == LAST_IDX)) state_nxt = FLUSH;
      end
      FLUSH: begin
        shift_en = 1'b1;
        emit     = 1'b1;
        if (ctr_addr == LAST_IDX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window as it will look after this shift: right column is the new
  // pixel plus the two line-buffer taps above it.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      win_sh[3*i]   = win_q[3*i+1];
      win_sh[3*i+1] = win_q[3*i+2];
      win_sh[3*i+2] = win_q[3*i+2];
    end
    win_sh[2] = tap2;
    win_sh[5] = tap1;
    win_sh[8] = push_pix;
  end

  assign top_out   = (ctr_row == '0);
  assign bot_out   = (ctr_row == LAST_ROW);
  assign left_out  = (ctr_col == '0);
  assign right_out = (ctr_col == LAST_COL);

`ifdef BLFT_EDGE_REPLICATE_EN
  logic [PIX_W-1:0] win_r [9];

  // Clamp rows onto the middle row, then columns onto the middle column.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      win_r[j]       = top_out ? win_sh[MID+j] : win_sh[j];
      win_r[MID+j]   = win_sh[MID+j];
      win_r[6+j]     = bot_out ? win_sh[MID+j] : win_sh[6+j];
    end
    for (int i = 0; i < 3; i++) begin
      win_m[3*i]   = left_out  ? win_r[3*i+1] : win_r[3*i];
      win_m[3*i+1] = win_r[3*i+1];
      win_m[3*i+2] = right_out ? win_r[3*i+1] : win_r[3*i+2];
    end
  end
`else
  // Edge masks also hide stale line-buffer data and line-wrap pixels.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if ((i == 0 && top_out) || (i == 2 && bot_out) ||
            (j == 0 && left_out) || (j == 2 && right_out)) begin
          win_m[3*i+j] = '0;
        end else begin
          win_m[3*i+j] = win_sh[3*i+j];
        end
      end
    end
  end
`endif

  always_comb begin
    win_flat = '0;
    for (int n = 0; n < 9; n++) begin
      win_flat[PIX_W*n +: PIX_W] = win_m[n];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_cnt     <= '0;
      ctr_addr  <= '0;
      ctr_row   <= '0;
      ctr_col   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_win   <= '0;
      out_done  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        k_cnt <= (k_cnt == LAST_IDX) ? '0 : k_cnt + 1'b1;
      end
      if ((accept && (in_addr != k_cnt)) || (in_valid && (state == FLUSH))) begin
        addr_err <= 1'b1;
      end
      if (shift_en) begin
        for (int n = 0; n < 9; n++) begin
          win_q[n] <= win_sh[n];
        end
      end
      out_valid <= emit;
      out_done  <= emit && (ctr_addr == LAST_IDX);
      if (emit) begin
        out_addr <= ctr_addr;
        out_win  <= win_flat;
        if (ctr_addr == LAST_IDX) begin
          ctr_addr <= '0;
          ctr_row  <= '0;
          ctr_col  <= '0;
        end else begin
          ctr_addr <= ctr_addr + 1'b1;
          if (ctr_col == LAST_COL) begin
            ctr_col <= '0;
            ctr_row <= ctr_row + 1'b1;
          end else begin
            ctr_col <= ctr_col + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_blft_win_gen.sv
// tb_blft_win_gen
//   Self-checking bench for blft_win_gen with a 4x4 frame whose pixel values
//   equal their addresses. Honours BLFT_EDGE_REPLICATE_EN for expectations.
module tb_blft_win_gen;

  localparam int W    = 4;
  localparam int H    = 4;
  localparam int PW   = 9;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [15:0]   in_addr;
  logic [8:0]    in_data;
  logic          out_valid;
  logic [15:0]   out_addr;
  logic [80:0]   out_win;
  logic          out_done;
  logic          addr_err;

  blft_win_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_win   (out_win),
    .out_done  (out_done),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [80:0] win;
    logic        done;
    int          cyc;
  } obs_t;

  typedef int nine_t [9];

  typedef struct {
    int          centre;
    logic [80:0] win;
    logic        done;
  } vec_t;

  obs_t obs_q [$];
  vec_t vecs [6];
  int   acc_cyc [2][NPIX];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(negedge clk) begin
    if (out_valid) obs_q.push_back('{out_addr, out_win, out_done, cyc});
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [80:0] pack9(input nine_t v);
    logic [80:0] r;
    r = '0;
    for (int n = 0; n < 9; n++) r[PW*n +: PW] = PW'(v[n]);
    return r;
  endfunction

  // Direct neighbourhood model: pixel at (row,col) has value row*W+col.
  function automatic logic [80:0] model_win(input int c);
    logic [80:0] r;
    int rr, cc, val;
    r = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = c / W + i - 1;
        cc = c % W + j - 1;
`ifdef BLFT_EDGE_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > H-1) rr = H-1;
        if (cc < 0) cc = 0;
        if (cc > W-1) cc = W-1;
`endif
        val = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? rr*W + cc : 0;
        r[PW*(3*i+j) +: PW] = PW'(val);
      end
    end
    return r;
  endfunction

  task automatic set_vec(input int idx, input int centre, input nine_t v, input logic done);
    vecs[idx].centre = centre;
    vecs[idx].win    = pack9(v);
    vecs[idx].done   = done;
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [8:0] data);
    in_valid = 1'b1;
    in_addr  = addr;
    in_data  = data;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int slot, input bit gaps, input int bad_idx);
    for (int k = 0; k < NPIX; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
      applyStimulus((k == bad_idx) ? 16'd9 : 16'(k), 9'(k));
      acc_cyc[slot][k] = cyc;
      if (bad_idx >= 0 && k == bad_idx - 1) checkOutput("addr_err_before_bad", addr_err, 0);
      if (k == bad_idx)                     checkOutput("addr_err_rise", addr_err, 1);
    end
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (out_valid && out_done) seen = 1'b1;
    end
    checkOutput("done_timeout", seen, 1);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input int base, input int slot, input string tag);
    int exp_cyc;
    for (int i = 0; i < NPIX; i++) begin
      if (base + i < obs_q.size()) begin
        checkOutput($sformatf("%s addr %0d", tag, i), obs_q[base+i].addr, i);
        checkOutput($sformatf("%s win c%0d", tag, i), obs_q[base+i].win, model_win(i));
        checkOutput($sformatf("%s done c%0d", tag, i), obs_q[base+i].done, (i == NPIX-1));
        if (slot >= 0) begin
          exp_cyc = (i < NPIX - W - 1) ? acc_cyc[slot][i+W+1] : acc_cyc[slot][NPIX-1] + (i - (NPIX - W - 2));
          checkOutput($sformatf("%s cycle c%0d", tag, i), obs_q[base+i].cyc, exp_cyc);
        end
      end else begin
        checkOutput($sformatf("%s missing c%0d", tag, i), 0, 1);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, " out_valid"}, out_valid, 0);
    checkOutput({tag, " out_addr"},  out_addr,  0);
    checkOutput({tag, " out_win"},   out_win,   0);
    checkOutput({tag, " out_done"},  out_done,  0);
    checkOutput({tag, " addr_err"},  addr_err,  0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
`ifdef BLFT_EDGE_REPLICATE_EN
    set_vec(0, 0,  '{0,0,1,    0,0,1,    4,4,5},       1'b0);
    set_vec(1, 5,  '{0,1,2,    4,5,6,    8,9,10},      1'b0);
    set_vec(2, 7,  '{2,3,3,    6,7,7,    10,11,11},    1'b0);
    set_vec(3, 15, '{10,11,11, 14,15,15, 14,15,15},    1'b1);
    set_vec(4, 12, '{8,8,9,    12,12,13, 12,12,13},    1'b0);
    set_vec(5, 3,  '{2,3,3,    2,3,3,    6,7,7},       1'b0);
`else
    set_vec(0, 0,  '{0,0,0,    0,0,1,    0,4,5},       1'b0);
    set_vec(1, 5,  '{0,1,2,    4,5,6,    8,9,10},      1'b0);
    set_vec(2, 7,  '{2,3,0,    6,7,0,    10,11,0},     1'b0);
    set_vec(3, 15, '{10,11,0,  14,15,0,  0,0,0},       1'b1);
    set_vec(4, 12, '{0,8,9,    0,12,13,  0,0,0},       1'b0);
    set_vec(5, 3,  '{0,0,0,    2,3,0,    6,7,0},       1'b0);
`endif

    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    $display("[TB] continuous frame followed by a back-to-back frame");
    obs_q.delete();
    run_frame(0, 1'b0, -1);
    wait_done();
    run_frame(1, 1'b0, -1);
    wait_done();
    settle();
    checkOutput("b2b window count", obs_q.size(), 2*NPIX);
    check_frame(0, 0, "f1");
    check_frame(NPIX, 1, "b2b");
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].centre < obs_q.size()) begin
        checkOutput($sformatf("vec%0d addr", v), obs_q[vecs[v].centre].addr, vecs[v].centre);
        checkOutput($sformatf("vec%0d win", v),  obs_q[vecs[v].centre].win,  vecs[v].win);
        checkOutput($sformatf("vec%0d done", v), obs_q[vecs[v].centre].done, vecs[v].done);
      end else begin
        checkOutput($sformatf("vec%0d missing", v), 0, 1);
      end
    end
    checkOutput("f1 addr_err", addr_err, 0);

    $display("[TB] frame with random in_valid gaps");
    obs_q.delete();
    run_frame(0, 1'b1, -1);
    wait_done();
    settle();
    checkOutput("gap window count", obs_q.size(), NPIX);
    check_frame(0, -1, "gap");
    checkOutput("gap addr_err", addr_err, 0);

    $display("[TB] reset after pixel 8, then a full frame");
    for (int k = 0; k <= 8; k++) applyStimulus(16'(k), 9'(k));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    rst = 1'b0;
    obs_q.delete();
    run_frame(0, 1'b0, -1);
    wait_done();
    settle();
    checkOutput("post_rst window count", obs_q.size(), NPIX);
    check_frame(0, 0, "post_rst");
    checkOutput("post_rst addr_err", addr_err, 0);

    $display("[TB] address 7 sent as 9");
    pulse_reset();
    obs_q.delete();
    run_frame(0, 1'b0, 7);
    wait_done();
    settle();
    checkOutput("bad_addr window count", obs_q.size(), NPIX);
    check_frame(0, 0, "bad_addr");
    checkOutput("addr_err sticky", addr_err, 1);

    $display("[TB] in_valid during flush");
    pulse_reset();
    obs_q.delete();
    run_frame(0, 1'b0, -1);
    applyStimulus(16'd0, 9'd99);
    wait_done();
    settle();
    checkOutput("flush_in window count", obs_q.size(), NPIX);
    check_frame(0, 0, "flush_in");
    checkOutput("flush_in addr_err", addr_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
